bus_slave: RTL and testbench



---
 rtl/bus_slave.sv | 171 +++++++++++++++++
 tb/tb_bus_slave.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// -----------------------------------------------------------------------------
// bus_slave
//   Serial-bus responder with a byte-wide local memory. A frame carries a
//   14-bit address (MSB first) on addr_rx; write frames carry a data byte on
//   data_rx alongside the last 8 address bits. Reads answer with a one-cycle
//   slave_valid strobe followed by the byte, MSB first, on data_tx.
//
// Parameters
//   SLAVE_ID : value address bits [13:12] must match to accept a frame
//   MEM_AW   : local memory address width (2**MEM_AW bytes)
//   RD_WAIT  : extra idle cycles (0-15) between memory read and slave_valid
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   valid_s        in   frame-valid; bits are sampled only while high
//   write_en_slave in   1=write, 0=read, captured on the first frame bit
//   addr_rx        in   serial address bit, bit 13 first
//   data_rx        in   serial write-data bit, valid on frame bits 6..13
//   slave_ready    out  1 in IDLE/RECV
//   slave_valid    out  one-cycle strobe preceding read data
//   data_tx        out  serial read data, MSB first
//   busy           out  1 in any state other than IDLE
// -----------------------------------------------------------------------------
module bus_slave #(
   parameter logic [1:0] SLAVE_ID = 2'd0,
   parameter int         MEM_AW   = 12,
   parameter int         RD_WAIT  = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic valid_s,
   input  logic write_en_slave,
   input  logic addr_rx,
   input  logic data_rx,
   output logic slave_ready,
   output logic slave_valid,
   output logic data_tx,
   output logic busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RECV   = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;
   localparam logic [2:0] S_SEND   = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_next_state;
   logic [3:0]  r_cnt;
   logic [13:0] r_addr;
   logic [7:0]  r_data;
   logic        r_we;
   logic        r_vs_d;
   logic [3:0]  r_wait;
   logic [7:0]  r_tx;
   logic [2:0]  r_bit_cnt;
   logic        r_ready;
   logic        r_valid;
   logic        r_tx_bit;
   logic        r_busy;

   logic [7:0]        r_mem [0:(1 << MEM_AW) - 1];
   logic [7:0]        r_mem_q;
   logic [MEM_AW-1:0] w_idx;
   logic              w_start;
   logic              w_id_ok;
   logic              w_mem_wr;
   logic              w_mem_rd;

   // A frame starts only on a low-to-high transition, so valid_s left high
   // after a previous frame cannot retrigger.
   assign w_start  = valid_s & ~r_vs_d;
   assign w_id_ok  = (r_addr[13:12] == SLAVE_ID);
   // Upper address bits beyond MEM_AW are dropped, so the index wraps.
   assign w_idx    = r_addr[MEM_AW-1:0];
   assign w_mem_wr = (r_state == S_DECODE) & w_id_ok & r_we;
   assign w_mem_rd = (r_state == S_DECODE) & w_id_ok & ~r_we;

   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_next_state = S_RECV;
         S_RECV:   if (valid_s && r_cnt == 4'd13) w_next_state = S_DECODE;
         S_DECODE: w_next_state = (!w_id_ok || r_we) ? S_IDLE : S_WAIT;
         S_WAIT:   if (r_wait == 4'(RD_WAIT)) w_next_state = S_RESP;
         S_RESP:   w_next_state = S_SEND;
         S_SEND:   if (r_bit_cnt == 3'd7) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_we      <= 1'b0;
         r_vs_d    <= 1'b0;
         r_wait    <= '0;
         r_tx      <= '0;
         r_bit_cnt <= '0;
         r_ready   <= 1'b1;
         r_valid   <= 1'b0;
         r_tx_bit  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_vs_d  <= valid_s;
         r_state <= w_next_state;
         // Outputs are registered from the state being entered, so they line
         // up with the state itself without any combinational output path.
         r_ready <= (w_next_state == S_IDLE) || (w_next_state == S_RECV);
         r_valid <= (w_next_state == S_RESP);
         r_busy  <= (w_next_state != S_IDLE);

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_addr <= {r_addr[12:0], addr_rx};
                  r_we   <= write_en_slave;
                  r_cnt  <= 4'd1;
               end
            end
            S_RECV: begin
               if (valid_s) begin
                  r_addr <= {r_addr[12:0], addr_rx};
                  if (r_cnt >= 4'd6) r_data <= {r_data[6:0], data_rx};
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_DECODE: r_wait <= '0;
            S_WAIT: begin
               if (r_wait == 4'(RD_WAIT)) r_tx <= r_mem_q;
               else                       r_wait <= r_wait + 4'd1;
            end
            S_RESP: begin
               // Present bit 7 for the first SEND cycle.
               r_tx_bit  <= r_tx[7];
               r_tx      <= {r_tx[6:0], 1'b0};
               r_bit_cnt <= '0;
            end
            S_SEND: begin
               if (r_bit_cnt == 3'd7) begin
                  r_tx_bit <= 1'b0;
               end else begin
                  r_tx_bit  <= r_tx[7];
                  r_tx      <= {r_tx[6:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: memory has no reset; only the control path decides when it is written.
   always_ff @(posedge clock) begin
      if (w_mem_wr) r_mem[w_idx] <= r_data;
      if (w_mem_rd) r_mem_q <= r_mem[w_idx];
   end

   assign slave_ready = r_ready;
   assign slave_valid = r_valid;
   assign data_tx     = r_tx_bit;
   assign busy        = r_busy;

endmodule

// File: tb/tb_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_slave
//   Directed bench for bus_slave. Two instances share all inputs: dut0 with
//   RD_WAIT=0 and dut3 with RD_WAIT=3 (both SLAVE_ID=0). Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_slave;

   logic clock;
   logic reset_n;
   logic valid_s;
   logic write_en_slave;
   logic addr_rx;
   logic data_rx;
   logic rdy0, sv0, tx0, busy0;
   logic rdy3, sv3, tx3, busy3;

   int n_checks = 0;
   int n_err    = 0;

   bus_slave #(.SLAVE_ID(2'd0), .MEM_AW(12), .RD_WAIT(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .valid_s(valid_s),
      .write_en_slave(write_en_slave), .addr_rx(addr_rx), .data_rx(data_rx),
      .slave_ready(rdy0), .slave_valid(sv0), .data_tx(tx0), .busy(busy0)
   );

   bus_slave #(.SLAVE_ID(2'd0), .MEM_AW(12), .RD_WAIT(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .valid_s(valid_s),
      .write_en_slave(write_en_slave), .addr_rx(addr_rx), .data_rx(data_rx),
      .slave_ready(rdy3), .slave_valid(sv3), .data_tx(tx3), .busy(busy3)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sends the first n_bits bits of a frame. An optional pause of pause_len
   // low cycles is inserted before bit pause_after. Returns on the falling
   // edge after the last bit, with valid_s left at hold_high.
   task automatic frame(input logic we, input logic [13:0] addr, input logic [7:0] data,
                        input int n_bits, input int pause_after, input int pause_len,
                        input logic hold_high);
      for (int i = 0; i < n_bits; i++) begin
         if (i == pause_after) begin
            for (int p = 0; p < pause_len; p++) begin
               @(negedge clock);
               valid_s = 1'b0;
               if (p == pause_len - 1) begin
                  check("split_cnt_hold", 32'(dut0.r_cnt), 32'd2);
                  check("split_busy", 32'(busy0), 32'd1);
                  check("split_ready", 32'(rdy0), 32'd1);
               end
            end
         end
         @(negedge clock);
         valid_s        = 1'b1;
         write_en_slave = we;
         addr_rx        = addr[13-i];
         data_rx        = (i >= 6) ? data[13-i] : 1'b0;
      end
      @(negedge clock);
      valid_s = hold_high;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy0 || busy3) && k < 50) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_idle_timeout"}, 32'(k < 50), 32'd1);
   endtask

   // Read frame, then measure strobe latency and collect the byte from the
   // selected instance.
   task automatic read_chk(input string tag, input logic [13:0] addr, input bit sel3,
                           input int exp_lat, input logic [7:0] exp_byte, input logic hold_high);
      int         lat = 0;
      logic [7:0] rx  = '0;
      frame(1'b0, addr, 8'h00, 14, -1, 0, hold_high);
      while (!(sel3 ? sv3 : sv0) && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_tx_in_resp"}, 32'(sel3 ? tx3 : tx0), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         rx = {rx[6:0], (sel3 ? tx3 : tx0)};
         if (k == 0) begin
            check({tag, "_strobe_len"}, 32'(sel3 ? sv3 : sv0), 32'd0);
            check({tag, "_ready_send"}, 32'(sel3 ? rdy3 : rdy0), 32'd0);
         end
      end
      check({tag, "_byte"}, 32'(rx), 32'(exp_byte));
      @(negedge clock);
      check({tag, "_tx_after"}, 32'(sel3 ? tx3 : tx0), 32'd0);
      wait_idle(tag);
   endtask

   initial begin
      logic seen_sv;
      reset_n        = 1'b0;
      valid_s        = 1'b0;
      write_en_slave = 1'b0;
      addr_rx        = 1'b0;
      data_rx        = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_ready", 32'(rdy0), 32'd1);
      check("rst_valid", 32'(sv0), 32'd0);
      check("rst_tx", 32'(tx0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Reset mid-RECV of a write: pre-clear target, then abort a write to it.
      frame(1'b1, 14'h0055, 8'h00, 14, -1, 0, 1'b0);
      frame(1'b1, 14'h0055, 8'h77, 9, -1, 0, 1'b0);
      check("midrecv_busy", 32'(busy0), 32'd1);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("abort_ready", 32'({rdy0, rdy3}), 32'b11);
      check("abort_valid", 32'({sv0, sv3}), 32'b00);
      check("abort_tx", 32'({tx0, tx3}), 32'b00);
      check("abort_busy", 32'({busy0, busy3}), 32'b00);
      reset_n = 1'b1;
      @(negedge clock);
      read_chk("abort_rd", 14'h0055, 1'b0, 2, 8'h00, 1'b0);

      // Write then immediate read of the same address.
      frame(1'b1, 14'h0123, 8'hA5, 14, -1, 0, 1'b0);
      read_chk("wr_rd", 14'h0123, 1'b0, 2, 8'hA5, 1'b0);

      // Split frame: valid_s low for 5 cycles after bit 2.
      frame(1'b1, 14'h0ABC, 8'h3C, 14, 2, 5, 1'b0);
      read_chk("split_rd", 14'h0ABC, 1'b0, 2, 8'h3C, 1'b0);

      // ID mismatch: frame discarded, memory untouched, busy drops after DECODE.
      frame(1'b1, 14'h1ABC, 8'hFF, 14, -1, 0, 1'b0);
      check("mis_busy_decode", 32'(busy0), 32'd1);
      @(negedge clock);
      check("mis_busy_done", 32'(busy0), 32'd0);
      seen_sv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         seen_sv = seen_sv | sv0 | sv3;
         @(negedge clock);
      end
      check("mis_no_strobe", 32'(seen_sv), 32'd0);
      read_chk("mis_rd", 14'h0ABC, 1'b0, 2, 8'h3C, 1'b0);

      // valid_s stuck high after a read frame: no retrigger until it drops.
      read_chk("stuck_rd", 14'h0123, 1'b0, 2, 8'hA5, 1'b1);
      repeat (4) @(negedge clock);
      check("stuck_no_frame", 32'({busy0, busy3}), 32'b00);
      valid_s = 1'b0;
      @(negedge clock);
      read_chk("stuck_rearm", 14'h0123, 1'b0, 2, 8'hA5, 1'b0);

      // RD_WAIT=3 instance: latency 5, bits contiguous.
      frame(1'b1, 14'h0FFF, 8'h5A, 14, -1, 0, 1'b0);
      read_chk("rdwait3", 14'h0FFF, 1'b1, 5, 8'h5A, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
